// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with shadowed codes, blanking, blinking
// and a dead-time cycle per digit slot. Define SEG_SCAN_DP_EN to add the decimal-point output.
module seg_scan_driver #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLINK_SCANS = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [5*DIGITS-1:0]   digit_codes,
   input  logic [DIGITS-1:0]     blank_mask,
   input  logic [DIGITS-1:0]     blink_mask,
`ifdef SEG_SCAN_DP_EN
   input  logic [DIGITS-1:0]     dp_mask,
   output logic                  dp_n,
`endif
   output logic [6:0]            seg_n,
   output logic [DIGITS-1:0]     an_n,
   output logic                  scan_wrap
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned BLK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_SCANS - 1);

   logic [CNT_W-1:0]    refresh_cnt;
   logic [IDX_W-1:0]    digit_idx;
   logic [BLK_W-1:0]    blink_cnt;
   logic                blink_hidden;
   logic [5*DIGITS-1:0] codes_sh;
   logic [DIGITS-1:0]   blank_sh;
   logic [DIGITS-1:0]   blink_sh;

   logic                tick;
   logic                wrap_evt;
   logic [4:0]          cur_code;
   logic                cur_blank;
   logic                cur_blink;
   logic                cur_dp;
   logic [DIGITS-1:0]   an_sel;
   logic                shown;

`ifdef SEG_SCAN_DP_EN
   logic [DIGITS-1:0]   dp_sh;
`endif

   function automatic logic [6:0] glyph(input logic [4:0] code);
      case (code)
         5'd1:    glyph = 7'h79;
         5'd2:    glyph = 7'h24;
         5'd3:    glyph = 7'h30;
         5'd4:    glyph = 7'h19;
         5'd5:    glyph = 7'h12;
         5'd6:    glyph = 7'h02;
         5'd7:    glyph = 7'h78;
         5'd8:    glyph = 7'h00;
         5'd9:    glyph = 7'h10;
         5'd10:   glyph = 7'h08;
         5'd11:   glyph = 7'h03;
         5'd12:   glyph = 7'h46;
         5'd13:   glyph = 7'h21;
         5'd14:   glyph = 7'h06;
         5'd15:   glyph = 7'h0E;
         5'd16:   glyph = 7'h42;
         5'd17:   glyph = 7'h09;
         5'd18:   glyph = 7'h4F;
         5'd19:   glyph = 7'h47;
         5'd20:   glyph = 7'h6A;
         5'd21:   glyph = 7'h0C;
         5'd22:   glyph = 7'h12;
         5'd23:   glyph = 7'h07;
         5'd24:   glyph = 7'h41;
         5'd25:   glyph = 7'h3F;
         default: glyph = 7'h40;
      endcase
   endfunction

   assign tick     = (refresh_cnt == CNT_MAX);
   assign wrap_evt = tick && (digit_idx == IDX_MAX);

   always_comb begin
      cur_code  = '0;
      cur_blank = 1'b0;
      cur_blink = 1'b0;
      cur_dp    = 1'b0;
      an_sel    = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (digit_idx == IDX_W'(i)) begin
            cur_code  = codes_sh[5*i +: 5];
            cur_blank = blank_sh[i];
            cur_blink = blink_sh[i];
`ifdef SEG_SCAN_DP_EN
            cur_dp    = dp_sh[i];
`endif
            an_sel[i] = 1'b1;
         end
      end
      shown = !cur_blank && !(cur_blink && blink_hidden);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         refresh_cnt  <= '0;
         digit_idx    <= '0;
         blink_cnt    <= '0;
         blink_hidden <= 1'b0;
         codes_sh     <= '0;
         blank_sh     <= '1;
         blink_sh     <= '1;
         seg_n        <= 7'h7F;
         an_n         <= '1;
         scan_wrap    <= 1'b0;
`ifdef SEG_SCAN_DP_EN
         dp_sh        <= '0;
         dp_n         <= 1'b1;
`endif
      end else begin
         if (load) begin
            codes_sh <= digit_codes;
            blank_sh <= blank_mask;
            blink_sh <= blink_mask;
`ifdef SEG_SCAN_DP_EN
            dp_sh    <= dp_mask;
`endif
         end

         refresh_cnt <= tick ? '0 : refresh_cnt + CNT_W'(1);
         if (tick) begin
            digit_idx <= (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
         end
         scan_wrap <= wrap_evt;

         if (wrap_evt) begin
            if (blink_cnt == BLK_MAX) begin
               blink_cnt    <= '0;
               blink_hidden <= ~blink_hidden;
            end else begin
               blink_cnt <= blink_cnt + BLK_W'(1);
            end
         end

         // Dead time at slot start; the slot's glyph is latched once and held so that a load
         // mid-slot only affects the following slot.
         if (refresh_cnt == '0) begin
            an_n  <= '1;
            seg_n <= 7'h7F;
`ifdef SEG_SCAN_DP_EN
            dp_n  <= 1'b1;
`endif
         end else if (refresh_cnt == CNT_W'(1)) begin
            an_n  <= shown ? ~an_sel : '1;
            seg_n <= shown ? glyph(cur_code) : 7'h7F;
`ifdef SEG_SCAN_DP_EN
            dp_n  <= shown ? ~cur_dp : 1'b1;
`endif
         end
      end
   end

`ifndef SEG_SCAN_DP_EN
   logic unused_dp;
   assign unused_dp = cur_dp;
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, REFRESH_DIV=4, BLINK_SCANS=2).
module tb_seg_scan_driver;
   localparam int unsigned DIGITS      = 4;
   localparam int unsigned REFRESH_DIV = 4;
   localparam int unsigned BLINK_SCANS = 2;

   logic        clk;
   logic        reset_n;
   logic        load;
   logic [19:0] digit_codes;
   logic [3:0]  blank_mask;
   logic [3:0]  blink_mask;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic        scan_wrap;
`ifdef SEG_SCAN_DP_EN
   logic [3:0]  dp_mask;
   logic        dp_n;
`endif

   typedef struct {
      int         n;
      logic [3:0] an;
      logic [6:0] seg;
      logic       wrap;
      logic       dp;
   } exp_t;

   typedef struct {
      logic [4:0] code;
      logic [6:0] seg;
   } glyph_vec_t;

   exp_t       exp_q[$];
   exp_t       cur;
   glyph_vec_t vecs[32];
   logic [6:0] seg_tab[32];
   int         checks   = 0;
   int         failures = 0;
   int         n        = 0;

   seg_scan_driver #(
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV),
      .BLINK_SCANS (BLINK_SCANS)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .load        (load),
      .digit_codes (digit_codes),
      .blank_mask  (blank_mask),
      .blink_mask  (blink_mask),
`ifdef SEG_SCAN_DP_EN
      .dp_mask     (dp_mask),
      .dp_n        (dp_n),
`endif
      .seg_n       (seg_n),
      .an_n        (an_n),
      .scan_wrap   (scan_wrap)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycles since reset release; cycle n is the interval after the n-th rising edge.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) n <= 0;
      else          n <= n + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s n=%0d actual=%0h required=%0h", name, n, act, req);
      end
   endtask

   // Output during cycle k reflects the slot state one cycle earlier; slot s = (k-1)/4.
   function automatic exp_t expect_cycle(input int k, input logic [19:0] codes,
                                         input logic [3:0] blank, input logic [3:0] blink,
                                         input logic [3:0] dpm);
      exp_t       e;
      int         s;
      int         slot;
      int         d;
      logic       hidden;
      logic [3:0] one;
      one    = 4'b0001;
      s      = k - 1;
      slot   = s / 4;
      d      = slot % 4;
      hidden = (((slot / 4) / 2) % 2) == 1;
      e.n    = k;
      e.wrap = (k % 16) == 0;
      e.an   = 4'hF;
      e.seg  = 7'h7F;
      e.dp   = 1'b1;
      if ((s % 4) != 0 && !blank[d] && !(blink[d] && hidden)) begin
         e.an  = ~(one << d);
         e.seg = seg_tab[codes[5*d +: 5]];
         e.dp  = ~dpm[d];
      end
      return e;
   endfunction

   task automatic push_range(input int first, input int last, input logic [19:0] codes_a,
                             input logic [19:0] codes_b, input int switch_slot,
                             input logic [3:0] blank, input logic [3:0] blink,
                             input logic [3:0] dpm);
      for (int k = first; k <= last; k++) begin
         exp_q.push_back(expect_cycle(k, (((k - 1) / 4) >= switch_slot) ? codes_b : codes_a,
                                      blank, blink, dpm));
      end
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].n < n) begin
         checks++;
         failures++;
         $display("FAIL missed n=%0d actual=none required=sample", exp_q[0].n);
         cur = exp_q.pop_front();
      end
      if (exp_q.size() > 0 && exp_q[0].n == n) begin
         cur = exp_q.pop_front();
         check("an_n", 32'(an_n), 32'(cur.an));
         check("seg_n", 32'(seg_n), 32'(cur.seg));
         check("scan_wrap", 32'(scan_wrap), 32'(cur.wrap));
`ifdef SEG_SCAN_DP_EN
         check("dp_n", 32'(dp_n), 32'(cur.dp));
`endif
      end
   end

   task automatic rel();
      reset_n = 1'b0;
      load    = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic load_now(input logic [19:0] codes, input logic [3:0] blank,
                           input logic [3:0] blink, input logic [3:0] dpm);
      load        = 1'b1;
      digit_codes = codes;
      blank_mask  = blank;
      blink_mask  = blink;
`ifdef SEG_SCAN_DP_EN
      dp_mask     = dpm;
`endif
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
         exp_q.delete();
      end
   endtask

   localparam logic [19:0] BASIC = {5'd4, 5'd3, 5'd2, 5'd1};
   localparam int          NEVER = 1000;

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                  7'h42, 7'h09, 7'h4F, 7'h47, 7'h6A, 7'h0C, 7'h12, 7'h07,
                  7'h41, 7'h3F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      for (int i = 0; i < 32; i++) begin
         vecs[i].code = 5'(i);
         vecs[i].seg  = seg_tab[i];
      end

      reset_n     = 1'b1;
      load        = 1'b0;
      digit_codes = '0;
      blank_mask  = '0;
      blink_mask  = '0;
`ifdef SEG_SCAN_DP_EN
      dp_mask     = '0;
`endif
      #2 reset_n = 1'b0;
      #1;
      check("rst_seg", 32'(seg_n), 32'h7F);
      check("rst_an", 32'(an_n), 32'hF);
      check("rst_wrap", 32'(scan_wrap), 32'h0);

      // No load after reset: shadow masks reset to blank, so nothing lights.
      rel();
      push_range(1, 20, 20'h0, 20'h0, NEVER, 4'hF, 4'h0, 4'h0);
      drain();

      // Basic scan over more than two full scans.
      rel();
      push_range(1, 40, BASIC, BASIC, NEVER, 4'h0, 4'h0, 4'b0100);
      load_now(BASIC, 4'h0, 4'h0, 4'b0100);
      drain();

      // Asynchronous reset while scan_wrap is high, then while a digit is lit.
      rel();
      load_now(BASIC, 4'h0, 4'h0, 4'h0);
      while (n != 16) @(negedge clk);
      #1;
      check("wrap_pre", 32'(scan_wrap), 32'h1);
      reset_n = 1'b0;
      #1;
      check("wrap_async_rst", 32'(scan_wrap), 32'h0);
      rel();
      load_now(BASIC, 4'h0, 4'h0, 4'h0);
      while (n != 22) @(negedge clk);
      #1;
      check("an_pre", 32'(an_n), 32'hD);
      check("seg_pre", 32'(seg_n), 32'h24);
      reset_n = 1'b0;
      #1;
      check("an_async_rst", 32'(an_n), 32'hF);
      check("seg_async_rst", 32'(seg_n), 32'h7F);
      check("wrap_async_rst2", 32'(scan_wrap), 32'h0);

      // Glyph sweep: same code on every digit, first two slots checked.
      for (int i = 0; i < 32; i++) begin
         rel();
         push_range(1, 8, {4{vecs[i].code}}, {4{vecs[i].code}}, NEVER, 4'h0, 4'h0, 4'h0);
         load_now({4{vecs[i].code}}, 4'h0, 4'h0, 4'h0);
         drain();
      end

      // Blank digit 1, blink digit 0: visible two scans, hidden two, visible again.
      rel();
      push_range(1, 80, BASIC, BASIC, NEVER, 4'b0010, 4'b0001, 4'h0);
      load_now(BASIC, 4'b0010, 4'b0001, 4'h0);
      drain();

      // Mid-slot load during digit 2 is superseded by a load on its tick cycle; digit 2 keeps
      // its old glyph for the whole slot and the next slot shows the tick-cycle values.
      rel();
      push_range(1, 32, BASIC, {5'd8, 5'd10, 5'd11, 5'd9}, 3, 4'h0, 4'h0, 4'b0100);
      load_now(BASIC, 4'h0, 4'h0, 4'b0100);
      while (n != 9) @(negedge clk);
      #1;
      load_now({4{5'd23}}, 4'h0, 4'h0, 4'b0100);
      while (n != 11) @(negedge clk);
      #1;
      load_now({5'd8, 5'd10, 5'd11, 5'd9}, 4'h0, 4'h0, 4'b0100);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for DIGITS common-anode seven-segment digits.
- Accepts one 5-bit glyph code per digit and decodes each with the team's standard glyph table.
- Scans the digits at a divided refresh rate, with per-digit blanking, per-digit blinking and dead-time between digits.
- Sits between game-control logic and the board display pins, and replaces per-digit static decoders.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 50000, clk cycles per digit slot (>=2).
- BLINK_SCANS, 64, full scans per blink half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; captures codes and masks.
- digit_codes  in  5*DIGITS  glyph code per digit; digit i = bits [5i+4:5i]; digit 0 is rightmost.
- blank_mask  in  DIGITS  1 = digit dark.
- blink_mask  in  DIGITS  1 = digit blinks.
- seg_n  out  7  segments, active-low; bit0=a … bit6=g.
- an_n  out  DIGITS  anode enables, active-low, one-hot-low.
- scan_wrap  out  1  one-cycle pulse when the digit index wraps to 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset state: seg_n=7'h7F, an_n=all 1s, scan_wrap=0.
  - Shadow codes=0, shadow masks=all 1s (blank).
  - Refresh counter, digit index, blink counter=0; blink phase=visible.
- Reset mid-scan returns to the reset state immediately. The first digit slot starts at digit 0 after release.
- Shadow registers:
  - On a clk edge with load=1, digit_codes, blank_mask and blink_mask are captured together.
  - The display uses only the shadow registers, so updates are coherent.
  - The new values appear from the next digit slot; the current slot's registered outputs are unaffected.
- Refresh counter: counts 0..REFRESH_DIV-1 and wraps. The tick is the cycle where it equals REFRESH_DIV-1.
- Digit index:
  - Increments on each tick, wrapping DIGITS-1 -> 0.
  - scan_wrap=1 for the cycle after the index becomes 0.
- Dead time: in the first cycle of every slot (refresh counter=0), an_n=all 1s. This prevents ghosting.
- Active part of slot: outputs are registered and use the current index (1-cycle latency).
  - Digit shown: an_n[index]=0, all other bits 1; seg_n=decode(code[index]).
  - Digit suppressed (blank_mask[index]=1, or blink_mask[index]=1 with blink phase=hidden): an_n=all 1s, seg_n=7'h7F.
- Blink: the blink counter counts scan wraps 0..BLINK_SCANS-1. Blink phase toggles when it wraps.
- Glyph table (code -> seg_n, binary g..a):
  - 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A(10)=0001000, B(11)=0000011, C(12)=1000110, D(13)=0100001, E(14)=0000110, F(15)=0001110
  - G(16)=1000010, H(17)=0001001, I(18)=1001111, L(19)=1000111, M(20)=1101010, P(21)=0001100, S(22)=0010010, T(23)=0000111, V(24)=1000001, dash(25)=0111111
  - 0 and all of 26..31 = 1000000.
- Simultaneous events: a load on the tick cycle is used by the slot that starts next.

Optional Feature:
- Macro: SEG_SCAN_DP_EN.
- Defined:
  - Adds ports dp_mask (in, DIGITS, captured with load; reset all 0s) and dp_n (out, 1, active-low).
  - dp_n=~dp_mask[index] while the digit is shown; otherwise dp_n=1.
  - dp_n obeys the same dead time, blank and blink rules as seg_n.
- Undefined: neither port exists and there is no dp logic.

Test Plan (DIGITS=4, REFRESH_DIV=4, BLINK_SCANS=2):
- Reset: hold reset_n=0 mid-slot -> seg_n=7F, an_n=F, scan_wrap=0 asynchronously. After release, the first slot shows digit 0.
- Basic scan: load codes {3:4,2:3,1:2,0:1} with masks 0 -> slots cycle an_n=E,D,B,7 with seg_n=79,24,30,19. Each slot has a leading cycle with an_n=F. scan_wrap pulses every 16 cycles.
- Full glyph sweep: codes 0..31 through digit 0 -> seg_n matches the table. Codes 26..31 give 40; code 8 gives 00; codes 5 and 22 both give 12.
- Blank and blink: blank_mask=0010, blink_mask=0001 -> digit 1 is never lit. Digit 0 is lit for 2 scans, dark for 2 scans, repeating.
- Load coherence: assert load on the tick cycle while digit 2 is active -> the next slot already shows the new code; digit 2's old glyph is held for its full slot.
- With SEG_SCAN_DP_EN: dp_mask=0100 -> dp_n=0 only during digit 2's active cycles; dp_n=1 during dead time.
